oled_spi_arbiter: RTL
=====================

// Module: oled_spi_arbiter
// PURPOSE
//   Shares the single OLED spi_fsm byte engine between NREQ requesters: page-command
//   updater, pixel-data sender and power-up init sequencer.
//   Grants the engine round-robin, one burst at a time, and forwards each byte with its
//   D/C level. Returns a per-byte ack to the owner and aborts stalled transfers with a
//   watchdog. Sits between the display FSMs and spi_fsm, replacing the local dc-based mux.
// PARAMETERS
//   NREQ     3      number of requesters (2..4)
//   TIMEOUT  1024   max clk cycles from spi_en rise to spi_fin before abort
//   TW       10     width of watchdog counter, $clog2(TIMEOUT)
// PORTS
//   clk       in   1        system clock; the only clock
//   rst_n     in   1        reset, asynchronous, active-low
//   req       in   NREQ     requester i wants the engine; held high for the whole burst
//   last      in   NREQ     byte presented by i is the final one of its burst
//   dc_in     in   NREQ     D/C level for i's byte (0 = command, 1 = data)
//   data_in   in   NREQ*8   byte of requester i at [8i+7:8i]
//   gnt       out  NREQ     one-hot; i currently owns the engine
//   ack       out  NREQ     1-cycle pulse: i's byte is shifted out, present the next one
//   err       out  1        1-cycle pulse: watchdog abort
//   spi_en    out  1        enable to spi_fsm
//   spi_data  out  8        byte to spi_fsm
//   dc        out  1        D/C pin to the OLED, stable while spi_en=1
//   spi_fin   in   1        spi_fsm byte-done strobe
// BEHAVIOUR
//   Reset: st=IDLE, gnt=0, ack=0, err=0, spi_en=0, spi_data=0, dc=1, ptr=NREQ-1, wdog=0.
//   FSM states: IDLE, LOAD, XFER, RELEASE. All outputs are registered.
//   IDLE:    if |req, winner = first set bit scanning ptr+1, ptr+2, ... (mod NREQ).
//            Set gnt[winner], store id, go to LOAD. Otherwise stay in IDLE.
//   LOAD:    latch spi_data=data_in[id], dc=dc_in[id], last_q=last[id].
//            Set spi_en=1, clear wdog, go to XFER.
//   XFER:    wdog increments each cycle.
//            On spi_fin: spi_en=0, ack[id]=1 for one cycle.
//              - last_q=1 or req[id]=0: go to RELEASE.
//              - otherwise go to LOAD (same owner, burst continues).
//            If wdog==TIMEOUT-1 and no spi_fin: spi_en=0, err=1, no ack, go to RELEASE.
//            spi_fin and timeout in the same cycle: spi_fin wins, no err.
//   RELEASE: gnt=0, ptr=id, go to IDLE.
//   Latency: req high in IDLE cycle N -> gnt at N+1 -> spi_en at N+2.
//            Bytes within a burst: spi_fin at cycle M -> next spi_en at M+2.
//            Bursts: at least 2 idle cycles (RELEASE, IDLE) between owners.
//   req[id] dropping while in XFER: the current byte completes, then release.
//     The owner must not drop req before its ack unless it accepts the byte being sent.
//   spi_fin outside XFER is ignored.
//   data_in/dc_in/last of requester i are sampled only in LOAD; they must be valid
//     while gnt[i]=1 and no ack is pending.
//   Fairness: a requester holding req continuously waits at most NREQ-1 bursts.
//   Async reset mid-transfer: spi_en drops immediately; spi_fsm sees en low and resets
//     its own state. No ack or err is generated.
//   dc holds its last value between bytes, so the OLED D/C pin never glitches.
// STRUCTURE
//   oled_pkg: typedef enum arb_st_e {IDLE, LOAD, XFER, RELEASE};
//             localparams REQ_CMD=0, REQ_DATA=1, REQ_INIT=2, OLED_TIMEOUT=1024.
//   Sub-module rr_pick #(N): combinational round-robin picker.
//     In: req[N], ptr.
//     Out: any, id.
//     Verified standalone.
//   The top level holds the FSM, registers, watchdog and output muxing.
// TESTING
//   T1 Single byte: req[1]=1, last[1]=1, data=8'hA5, dc=1; spi_fin 8 cycles after spi_en
//      -> gnt=3'b010 at N+1, spi_en at N+2 with spi_data=A5 dc=1, one ack[1], gnt=0 after.
//   T2 Burst: req[0] with 3 bytes 8'hB0, 8'h00, 8'h10, dc=0, last on the 3rd
//      -> 3 spi_en pulses in order, 3 acks, gnt[0] held throughout, no other grant.
//   T3 Fairness: req=3'b111 held, each a 1-byte burst, ptr=2 after reset
//      -> grant order 0, 1, 2, 0, ...
//   T4 Watchdog: spi_fin never asserted -> after TIMEOUT cycles spi_en=0, err=1 for one
//      cycle, no ack, next requester granted.
//   T5 Coincidence: spi_fin lands exactly on cycle TIMEOUT-1 -> ack, no err.
//      Also: req[id] dropped mid-XFER -> current byte acked, then release.
//   T6 Reset: rst_n low mid-XFER -> spi_en=0, gnt=0, dc=1 asynchronously.
//      After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/oled_spi_arbiter_pkg.sv
// Shared state type and constants for the OLED SPI engine arbiter.
package oled_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, XFER, RELEASE} arb_st_e;

   localparam int REQ_CMD      = 0;
   localparam int REQ_DATA     = 1;
   localparam int REQ_INIT     = 2;
   localparam int OLED_TIMEOUT = 1024;
endpackage

// File: rtl/oled_spi_arbiter_if.sv
// Requester-side and spi_fsm-side signals of the OLED SPI engine arbiter.
interface oled_spi_arbiter_if #(parameter int NREQ = 3);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   last;
   logic [NREQ-1:0]   dc_in;
   logic [NREQ*8-1:0] data_in;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   ack;
   logic              err;
   logic              spi_en;
   logic [7:0]        spi_data;
   logic              dc;
   logic              spi_fin;

   modport master (
      output req, last, dc_in, data_in, spi_fin,
      input  gnt, ack, err, spi_en, spi_data, dc
   );

   modport slave (
      input  req, last, dc_in, data_in, spi_fin,
      output gnt, ack, err, spi_en, spi_data, dc
   );
endinterface

// File: rtl/oled_spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_any,
   output logic [IW-1:0] o_id
);
   // Scan farthest to nearest so the nearest candidate after i_ptr is written last.
   always_comb begin
      o_any = 1'b0;
      o_id  = '0;
      for (int k = N; k >= 1; k--) begin
         if (i_req[IW'((int'(i_ptr) + k) % N)]) begin
            o_any = 1'b1;
            o_id  = IW'((int'(i_ptr) + k) % N);
         end
      end
   end
endmodule

// File: rtl/oled_spi_arbiter.sv
// Round-robin owner of the OLED spi_fsm byte engine with per-byte ack and transfer watchdog.
//   state   | meaning
//   IDLE    | no owner; pick next requester after ptr
//   LOAD    | latch owner's byte/dc/last, raise spi_en
//   XFER    | byte in flight; wait spi_fin or watchdog expiry
//   RELEASE | drop grant, move ptr to the finished owner
module oled_spi_arbiter
   import oled_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = OLED_TIMEOUT,
   parameter int TW      = $clog2(TIMEOUT)
) (
   input  logic               clk,
   input  logic               rst_n,
   oled_spi_arbiter_if.slave  bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_st_e         r_st,       w_st_nxt;
   logic [NREQ-1:0] r_gnt,      w_gnt_nxt;
   logic [NREQ-1:0] r_ack,      w_ack_nxt;
   logic            r_err,      w_err_nxt;
   logic            r_spi_en,   w_spi_en_nxt;
   logic [7:0]      r_spi_data, w_spi_data_nxt;
   logic            r_dc,       w_dc_nxt;
   logic            r_last_q,   w_last_q_nxt;
   logic [IW-1:0]   r_ptr,      w_ptr_nxt;
   logic [IW-1:0]   r_id,       w_id_nxt;
   logic [TW-1:0]   r_wdog,     w_wdog_nxt;
   logic            w_any;
   logic [IW-1:0]   w_pick;

   rr_pick #(.N(NREQ), .IW(IW)) u_pick (
      .i_req (bus.req),
      .i_ptr (r_ptr),
      .o_any (w_any),
      .o_id  (w_pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st       <= IDLE;
         r_gnt      <= '0;
         r_ack      <= '0;
         r_err      <= 1'b0;
         r_spi_en   <= 1'b0;
         r_spi_data <= '0;
         r_dc       <= 1'b1;
         r_last_q   <= 1'b0;
         r_ptr      <= IW'(NREQ - 1);
         r_id       <= '0;
         r_wdog     <= '0;
      end else begin
         r_st       <= w_st_nxt;
         r_gnt      <= w_gnt_nxt;
         r_ack      <= w_ack_nxt;
         r_err      <= w_err_nxt;
         r_spi_en   <= w_spi_en_nxt;
         r_spi_data <= w_spi_data_nxt;
         r_dc       <= w_dc_nxt;
         r_last_q   <= w_last_q_nxt;
         r_ptr      <= w_ptr_nxt;
         r_id       <= w_id_nxt;
         r_wdog     <= w_wdog_nxt;
      end
   end

   always_comb begin
      w_st_nxt       = r_st;
      w_gnt_nxt      = r_gnt;
      w_ack_nxt      = '0;
      w_err_nxt      = 1'b0;
      w_spi_en_nxt   = r_spi_en;
      w_spi_data_nxt = r_spi_data;
      w_dc_nxt       = r_dc;
      w_last_q_nxt   = r_last_q;
      w_ptr_nxt      = r_ptr;
      w_id_nxt       = r_id;
      w_wdog_nxt     = r_wdog;
      case (r_st)
         IDLE: begin
            if (w_any) begin
               w_gnt_nxt         = '0;
               w_gnt_nxt[w_pick] = 1'b1;
               w_id_nxt          = w_pick;
               w_st_nxt          = LOAD;
            end
         end
         LOAD: begin
            w_spi_data_nxt = bus.data_in[int'(r_id)*8 +: 8];
            w_dc_nxt       = bus.dc_in[r_id];
            w_last_q_nxt   = bus.last[r_id];
            w_spi_en_nxt   = 1'b1;
            w_wdog_nxt     = '0;
            w_st_nxt       = XFER;
         end
         XFER: begin
            w_wdog_nxt = r_wdog + 1'b1;
            // A completed byte takes precedence over a watchdog expiry in the same cycle.
            if (bus.spi_fin) begin
               w_spi_en_nxt    = 1'b0;
               w_ack_nxt[r_id] = 1'b1;
               w_st_nxt        = (r_last_q || !bus.req[r_id]) ? RELEASE : LOAD;
            end else if (r_wdog == TW'(TIMEOUT - 1)) begin
               w_spi_en_nxt = 1'b0;
               w_err_nxt    = 1'b1;
               w_st_nxt     = RELEASE;
            end
         end
         RELEASE: begin
            w_gnt_nxt = '0;
            w_ptr_nxt = r_id;
            w_st_nxt  = IDLE;
         end
         default: w_st_nxt = IDLE;
      endcase
   end

   assign bus.gnt      = r_gnt;
   assign bus.ack      = r_ack;
   assign bus.err      = r_err;
   assign bus.spi_en   = r_spi_en;
   assign bus.spi_data = r_spi_data;
   assign bus.dc       = r_dc;
endmodule
